// File: rtl/bus_access_sequencer.sv
// ---------------------------------------------------------------------------
// bus_access_sequencer
//
// Sequences one CPU load/store at a time onto a 32-bit req/ack memory bus.
// Loads return through an external data-bus organizer: the captured memory
// word goes out on o_org_db with a control code on o_org_ctrl. The organized
// word comes back on i_org_data, where the wanted byte or half is selected
// and extended.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_cpu_*            request side: req, we, size, signed, addr, wdata
//   o_cpu_ready/err    one-cycle completion pulse and error flag
//   o_cpu_rdata        load result, held until the next load completes
//   o_busy             high whenever the sequencer is not idle
//   o_mem_*/i_mem_*    memory bus: req, we, be, addr, wdata / ack, rdata
//   o_org_db/o_org_ctrl, i_org_data   organizer interface
// ---------------------------------------------------------------------------
module bus_access_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [1:0]  i_cpu_size,
    input  logic        i_cpu_signed,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic        o_cpu_ready,
    output logic        o_cpu_err,
    output logic [31:0] o_cpu_rdata,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_org_db,
    output logic [1:0]  o_org_ctrl,
    input  logic [31:0] i_org_data
);

    localparam logic [1:0] SizeWord = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeByte = 2'b10;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StAlign,
        StResp,
        StErrResp
    } state_e;

    state_e      r_state;
    state_e      w_next_state;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_org_db;
    logic [1:0]  r_org_ctrl;
    logic [31:0] r_cpu_rdata;

    logic        w_accept;
    logic        w_fault;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [1:0]  w_ctrl;
    logic [7:0]  w_byte;
    logic [31:0] w_load_result;

    assign w_accept  = (r_state == StIdle) && i_cpu_req;
    // Last allowed ACCESS cycle: the counter reaches TIMEOUT_CYCLES at its end.
    assign w_timeout = (r_cnt == CntLast);

    // Request decode: alignment check, lane enables, lane replication, organizer code.
    always_comb begin
        w_fault = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        w_ctrl  = 2'b00;
        unique case (i_cpu_size)
            SizeWord: begin
                w_fault = (i_cpu_addr[1:0] != 2'b00);
                w_be    = 4'b1111;
                w_wdata = i_cpu_wdata;
                w_ctrl  = 2'b00;
            end
            SizeHalf: begin
                w_fault = i_cpu_addr[0];
                w_be    = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_cpu_wdata[15:0]}};
                w_ctrl  = i_cpu_addr[1] ? 2'b10 : 2'b01;
            end
            SizeByte: begin
                w_fault = 1'b0;
                w_be    = 4'b0001 << i_cpu_addr[1:0];
                w_wdata = {4{i_cpu_wdata[7:0]}};
                w_ctrl  = i_cpu_addr[1] ? 2'b10 : 2'b01;
            end
            default: begin
                w_fault = 1'b1;
            end
        endcase
    end

    // The organizer has already moved the target half into bits 15:0.
    always_comb begin
        w_byte        = r_addr_lo[0] ? i_org_data[15:8] : i_org_data[7:0];
        w_load_result = i_org_data;
        unique case (r_size)
            SizeHalf: w_load_result = {{16{r_signed & i_org_data[15]}}, i_org_data[15:0]};
            SizeByte: w_load_result = {{24{r_signed & w_byte[7]}}, w_byte};
            default:  w_load_result = i_org_data;
        endcase
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b1;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_cpu_ready  = 1'b0;
        o_cpu_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_cpu_req) begin
                    w_next_state = w_fault ? StErrResp : StAccess;
                end
            end
            StAccess: begin
                o_mem_req = 1'b1;
                o_mem_we  = r_we;
                // Ack takes priority over an expiring timeout.
                if (i_mem_ack) begin
                    w_next_state = r_we ? StResp : StAlign;
                end else if (w_timeout) begin
                    w_next_state = StErrResp;
                end
            end
            StAlign: begin
                w_next_state = StResp;
            end
            StResp: begin
                o_cpu_ready  = 1'b1;
                w_next_state = StIdle;
            end
            StErrResp: begin
                o_cpu_ready  = 1'b1;
                o_cpu_err    = 1'b1;
                w_next_state = StIdle;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_cnt       <= 8'd0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_org_db    <= 32'h0;
            r_org_ctrl  <= 2'b00;
            r_cpu_rdata <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we      <= i_cpu_we;
                r_size    <= i_cpu_size;
                r_signed  <= i_cpu_signed;
                r_addr_lo <= i_cpu_addr[1:0];
                r_cnt     <= 8'd0;
                // Bus-facing registers only move for accesses that reach the bus.
                if (!w_fault) begin
                    r_mem_addr  <= {i_cpu_addr[31:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                    r_org_ctrl  <= w_ctrl;
                end
            end
            if (r_state == StAccess) begin
                r_cnt <= r_cnt + 8'd1;
                if (i_mem_ack && !r_we) begin
                    r_org_db <= i_mem_rdata;
                end
            end
            if (r_state == StAlign) begin
                r_cpu_rdata <= w_load_result;
            end
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
    assign o_org_db    = r_org_db;
    assign o_org_ctrl  = r_org_ctrl;
    assign o_cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_bus_access_sequencer.sv
module tb_bus_access_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic        cpu_signed = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_ready, cpu_err, busy, mem_req, mem_we;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, org_db, org_data;
    logic [3:0]  mem_be;
    logic [1:0]  org_ctrl;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_total = 0;
    int n_bad = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    // Downstream organizer: code 10 swaps the halves, anything else passes through.
    assign org_data = (org_ctrl == 2'b10) ? {org_db[15:0], org_db[31:16]} : org_db;

    bus_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size),
        .i_cpu_signed(cpu_signed), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ready(cpu_ready), .o_cpu_err(cpu_err), .o_cpu_rdata(cpu_rdata),
        .o_busy(busy), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_org_db(org_db), .o_org_ctrl(org_ctrl), .i_org_data(org_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference load result: shift the addressed bytes down, mask, extend.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] mem);
        logic [31:0] v;
        v = mem >> (32'(addr[1:0]) * 8);
        case (size)
            2'd1: begin
                v = v & 32'h0000_FFFF;
                if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            2'd2: begin
                v = v & 32'h0000_00FF;
                if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            default: v = mem;
        endcase
        return v;
    endfunction

    // delay: ACCESS cycles before ack (0 = first cycle); negative = never ack.
    task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem_word, input int delay);
        bit          fault, tmo, field_chk, done;
        int          exp_req_cycles, exp_lat, req_cycles, n;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        logic [1:0]  exp_ctrl;

        fault = (size == 2'd3) || (size == 2'd0 && addr[1:0] != 2'b00) ||
                (size == 2'd1 && addr[0]);
        tmo   = !fault && (delay < 0 || delay >= TO);
        exp_req_cycles = fault ? 0 : (tmo ? TO : delay + 1);
        exp_lat = fault ? 2 : (tmo ? TO + 2 : (we ? delay + 3 : delay + 4));
        exp_be  = (size == 2'd0) ? 4'hF : ((size == 2'd1) ? 4'h3 : 4'h1) << addr[1:0];
        exp_wd  = (size == 2'd0) ? wdata :
                  (size == 2'd1) ? (wdata & 32'hFFFF) * 32'h0001_0001 :
                                   (wdata & 32'hFF) * 32'h0101_0101;
        exp_ctrl = (size == 2'd0) ? 2'd0 : (addr[1] ? 2'd2 : 2'd1);
        exp_rd  = (!we && !fault && !tmo) ? ref_load(size, sgn, addr, mem_word) : last_rdata;

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
        cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 1;
        req_cycles = 0;
        field_chk = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                req_cycles++;
                if (!field_chk || req_cycles == exp_req_cycles) begin
                    field_chk = 1;
                    check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    check_eq("mem_we", 32'(mem_we), 32'(we));
                    check_eq("mem_be", 32'(mem_be), 32'(exp_be));
                    if (we) check_eq("mem_wdata", mem_wdata, exp_wd);
                    else check_eq("org_ctrl", 32'(org_ctrl), 32'(exp_ctrl));
                end
                mem_ack   = (delay >= 0) && (req_cycles - 1 == delay);
                mem_rdata = mem_ack ? mem_word : $urandom;
            end else begin
                mem_ack   = 1'($urandom);     // must be ignored outside ACCESS
                mem_rdata = $urandom;
            end
            if (cpu_ready) begin
                done = 1;
                check_eq("latency", 32'(n), 32'(exp_lat));
                check_eq("cpu_err", 32'(cpu_err), 32'(fault || tmo));
                check_eq("req_cycles", 32'(req_cycles), 32'(exp_req_cycles));
                check_eq("cpu_rdata", cpu_rdata, exp_rd);
                if (!we && !fault && !tmo) check_eq("org_db", org_db, mem_word);
                last_rdata = exp_rd;
                cpu_req = 1'b0;
            end else begin
                // Requests while busy must be ignored.
                cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_size = 2'($urandom);
                cpu_addr = $urandom; cpu_wdata = $urandom;
                if (n > TO + 30) begin
                    check_eq("ready_wait", 32'(n), 32'(exp_lat));
                    done = 1;
                end
            end
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(cpu_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_be", 32'(mem_be), 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_org", {org_ctrl, org_db[29:0]}, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'hA1B2_C3D4, 0);
        run_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 0);
        run_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 0);
        run_op(1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 32'h7F00_0000, 0);
        run_op(1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 32'h8000_0000, 0);
        run_op(1'b1, 2'd2, 1'b0, 32'h201, 32'h0000_00AB, 32'h0, 0);
        run_op(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h1234_5678, 0);
        run_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);
        run_op(1'b0, 2'd0, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, -1);
        run_op(1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 32'h1122_3344, TO - 1);
        run_op(1'b1, 2'd1, 1'b0, 32'h10A, 32'hCAFE_5A5A, 32'h0, 2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            run_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom,
                   ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3)));
        end

        // Reset in the middle of an access
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd0; cpu_addr = 32'h40;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(cpu_ready), 32'd0);
        check_eq("mid_rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_ready", 32'(cpu_ready), 32'd0);
        end
        run_op(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h7FFF_0000, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_access_sequencer.md
Name: bus_access_sequencer

Overview:
Sequences single load/store accesses between the CPU-side load/store port and a 32-bit memory bus with a req/ack handshake. Drives the control code of the downstream data-bus organizer and feeds it the registered memory word. Takes the organized word back and applies byte-select and sign/zero extension. Checks alignment and enforces an ack timeout. Sits between the core's memory stage and the external memory interface.

Parameters:
TIMEOUT_CYCLES, 16, number of ACCESS-state cycles without mem_ack before the access is aborted with an error (range 2..255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  access request; sampled only in IDLE
cpu_we  in  1  1 = store, 0 = load
cpu_size  in  2  00 word, 01 halfword, 10 byte, 11 illegal
cpu_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-justified
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_ready; 1 = misaligned, illegal size or timeout
cpu_rdata  out  32  load result, valid with cpu_ready
busy  out  1  high in every state except IDLE
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  memory write enable
mem_be  out  4  byte enables; bit i = byte lane i (lane 0 = bits 7:0)
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  store data replicated into lanes
mem_ack  in  1  memory completion; mem_rdata valid same cycle for loads
mem_rdata  in  32  memory read data
org_db  out  32  registered memory word to the organizer
org_ctrl  out  2  organizer control code
org_data  in  32  organized word from the organizer (combinational)

Behaviour:
- Reset (async): state=IDLE. cpu_ready, cpu_err, busy, mem_req, mem_we = 0. mem_be=0. cpu_rdata, mem_addr, mem_wdata, org_db = 0. org_ctrl=00. Timeout counter = 0.
- IDLE: when cpu_req=1, latch we/size/signed/addr/wdata.
  - Alignment check: word needs addr[1:0]=00; halfword needs addr[0]=0; size 11 is illegal.
  - Fault → ERR_RESP. No mem_req is ever issued for a faulting access.
  - Otherwise → ACCESS.
- ACCESS: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are stable for the whole state.
  - mem_be: word=1111; halfword = 0011 or 1100 selected by addr[1]; byte = one-hot on addr[1:0].
  - mem_wdata: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
  - Counter increments each cycle in ACCESS.
  - On mem_ack, store → RESP; load → capture mem_rdata into org_db, then → ALIGN.
  - If the counter reaches TIMEOUT_CYCLES with no ack → ERR_RESP.
  - mem_req drops the cycle after ack or timeout.
  - If mem_ack and timeout occur in the same cycle, ack wins.
- org_ctrl, held from ACCESS through ALIGN:
  - word = 00.
  - half/byte with addr[1]=0 → 01 (pass-through).
  - half/byte with addr[1]=1 → 10 (halves swapped, so the target half arrives in bits 15:0).
  - Code 11 is never driven.
- ALIGN (1 cycle): sample org_data.
  - word → as-is.
  - half → org_data[15:0], extended to 32 bits.
  - byte → org_data[7:0] if addr[0]=0, else org_data[15:8], then extended.
  - Result is registered into cpu_rdata → RESP.
- RESP (1 cycle): cpu_ready=1, cpu_err=0 → IDLE. cpu_rdata holds its value until the next load completes (stores leave it unchanged).
- ERR_RESP (1 cycle): cpu_ready=1, cpu_err=1, cpu_rdata unchanged → IDLE.
- Latency, request to cpu_ready (no wait states):
  - Load with mem_ack in the first ACCESS cycle: 4 cycles (IDLE→ACCESS→ALIGN→RESP).
  - Store: 3 cycles.
  - Alignment fault: 2 cycles.
- cpu_req is ignored while busy=1, and also in the RESP/ERR_RESP cycles. Back-to-back requests are accepted in the IDLE cycle that follows RESP.
- mem_ack outside ACCESS is ignored.
- Reset asserted mid-access aborts immediately: all outputs go to reset values and no cpu_ready is generated.

Test Plan:
- Word load, addr 0x100, mem_rdata=0xA1B2C3D4, ack in 1st ACCESS cycle → org_ctrl=00, cpu_ready at cycle 4, cpu_rdata=0xA1B2C3D4, cpu_err=0.
- Signed halfword load, addr 0x102, mem_rdata=0x8001_1234 → org_ctrl=10, cpu_rdata=0xFFFF8001. Same access unsigned → 0x00008001.
- Byte load, addr 0x103, mem_rdata=0x7F00_0000, signed → cpu_rdata=0x0000007F. Repeat with 0x8000_0000 → 0xFFFFFF80.
- Byte store, addr 0x201, wdata=0x000000AB → mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x200, cpu_ready 3 cycles after request, cpu_err=0.
- Misaligned word load at addr 0x102, and cpu_size=11 → mem_req never asserted, cpu_ready+cpu_err pulse 2 cycles after request.
- mem_ack withheld (TIMEOUT_CYCLES=16) → mem_req high exactly 16 cycles, then cpu_err=1. Separately, assert rst during ACCESS → mem_req=0, busy=0 immediately, no cpu_ready.
